// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Time-multiplexed driver for a 4-digit common-anode seven-segment display.
//   Captures four BCD nibbles (plus decimal-point enables and the leading-zero
//   blanking mode) once per frame and scans them one digit per slot. Each slot
//   starts with a guard interval with every anode off to avoid ghosting. An
//   optional whole-display blink gates the anodes at a frame-based rate.
//
// Ports
//   clk         system clock
//   reset       synchronous, active-high reset
//   bcd3..bcd0  digit nibbles, bcd3 = leftmost digit
//   dp_en[3:0]  decimal-point enable, bit i -> digit i
//   blank_lz    1 = blank leading zeros
//   blink       1 = flash the whole display (sampled live)
//   an[3:0]     anode selects, bit i -> digit i
//   seg[6:0]    segments {g,f,e,d,c,b,a}
//   dp          decimal-point segment
//   frame_tick  one-cycle pulse when a new frame's digits have been captured
module seg7_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 1000,
    parameter int BLINK_FRAMES = 125,
    parameter bit ACTIVE_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] bcd3,
    input  logic [3:0] bcd2,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    input  logic [3:0] dp_en,
    input  logic       blank_lz,
    input  logic       blink,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       frame_tick
);

    localparam int DW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [DW-1:0] DIV_MAX   = DW'(REFRESH_DIV - 1);
    localparam logic [DW-1:0] GUARD_V   = DW'(GUARD);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_FRAMES - 1);

    // Inactive levels; XOR with these converts active-high internals to pin polarity.
    localparam logic [3:0] AN_OFF  = ACTIVE_LOW ? 4'hF  : 4'h0;
    localparam logic [6:0] SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = ACTIVE_LOW ? 1'b1  : 1'b0;

    logic [DW-1:0]   div_cnt_q, div_cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] sh_dig_q, sh_dig_d;
    logic [3:0]      sh_dp_q, sh_dp_d;
    logic            sh_blz_q, sh_blz_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_ph_q, blink_ph_d;
    logic            first_q, first_d;
    logic [3:0]      an_q, an_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;
    logic            frame_tick_q, frame_tick_d;

    logic       slot_end, frame_end, capture;
    logic [3:0] cur_dig;
    logic       blanked, lit;
    logic [3:0] an_hi;
    logic [6:0] seg_hi;
    logic       dp_hi;

    always_comb begin
        slot_end  = (div_cnt_q == DIV_MAX);
        frame_end = slot_end && (idx_q == 2'd3);
        // first_q forces a capture right after reset so the first frame is valid.
        capture   = first_q || frame_end;

        div_cnt_d = slot_end ? '0 : div_cnt_q + 1'b1;
        idx_d     = slot_end ? idx_q + 2'd1 : idx_q;
        first_d   = 1'b0;

        sh_dig_d = sh_dig_q;
        sh_dp_d  = sh_dp_q;
        sh_blz_d = sh_blz_q;
        if (capture) begin
            sh_dig_d = {bcd3, bcd2, bcd1, bcd0};
            sh_dp_d  = dp_en;
            sh_blz_d = blank_lz;
        end

        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;
        if (frame_end) begin
            if (blink_cnt_q == BLINK_MAX) begin
                blink_cnt_d = '0;
                blink_ph_d  = ~blink_ph_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
            end
        end

        cur_dig = sh_dig_q[idx_q];

        // A digit is a leading zero only if it and every digit to its left are zero.
        blanked = 1'b0;
        case (idx_q)
            2'd3: blanked = sh_blz_q && (sh_dig_q[3] == 4'd0);
            2'd2: blanked = sh_blz_q && (sh_dig_q[3] == 4'd0) && (sh_dig_q[2] == 4'd0);
            2'd1: blanked = sh_blz_q && (sh_dig_q[3] == 4'd0) && (sh_dig_q[2] == 4'd0)
                            && (sh_dig_q[1] == 4'd0);
            default: blanked = 1'b0;
        endcase

        case (cur_dig)
            4'd0:    seg_hi = 7'h3F;
            4'd1:    seg_hi = 7'h06;
            4'd2:    seg_hi = 7'h5B;
            4'd3:    seg_hi = 7'h4F;
            4'd4:    seg_hi = 7'h66;
            4'd5:    seg_hi = 7'h6D;
            4'd6:    seg_hi = 7'h7D;
            4'd7:    seg_hi = 7'h07;
            4'd8:    seg_hi = 7'h7F;
            4'd9:    seg_hi = 7'h6F;
            default: seg_hi = 7'h40;
        endcase

        lit   = !blanked && (div_cnt_q >= GUARD_V) && !(blink && blink_ph_q);
        an_hi = lit ? (4'b0001 << idx_q) : 4'b0000;
        dp_hi = !blanked && sh_dp_q[idx_q];

        an_d         = an_hi ^ AN_OFF;
        seg_d        = seg_hi ^ SEG_OFF;
        dp_d         = dp_hi ^ DP_OFF;
        frame_tick_d = capture;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt_q    <= '0;
            idx_q        <= 2'd0;
            sh_dig_q     <= '0;
            sh_dp_q      <= 4'd0;
            sh_blz_q     <= 1'b0;
            blink_cnt_q  <= '0;
            blink_ph_q   <= 1'b0;
            first_q      <= 1'b1;
            an_q         <= AN_OFF;
            seg_q        <= SEG_OFF;
            dp_q         <= DP_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            sh_dig_q     <= sh_dig_d;
            sh_dp_q      <= sh_dp_d;
            sh_blz_q     <= sh_blz_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_ph_q   <= blink_ph_d;
            first_q      <= first_d;
            an_q         <= an_d;
            seg_q        <= seg_d;
            dp_q         <= dp_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign an         = an_q;
    assign seg        = seg_q;
    assign dp         = dp_q;
    assign frame_tick = frame_tick_q;

endmodule
